// File: rtl/ecc_dec_ctrl_if.sv
// Handshake bundle for the SEC-DED sequencing controller: word input side and
// decoded result side. The controller attaches through the slave modport.
interface ecc_dec_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH-1:0]     in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_WIDTH/2-1:0]   out_data;
   logic [DATA_WIDTH/8-1:0]   out_corr;
   logic [DATA_WIDTH/8-1:0]   out_err;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_corr,
      input  out_err
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_corr,
      output out_err
   );
endinterface

// File: rtl/ecc_dec_ctrl.sv
// Sequencing controller sharing one 8-bit SEC-DED syndrome unit across the lanes
// of a word, one lane per cycle. Optional statistics counters: ECC_DEC_STATS_EN.
module ecc_dec_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   ecc_dec_ctrl_if.slave bus,
   input  logic          cnt_clr,
   output logic [15:0]   corr_cnt,
   output logic [15:0]   derr_cnt
);
   localparam int N  = DATA_WIDTH / 8;
   localparam int LW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [DATA_WIDTH-1:0]   lane_buf;
   logic [LW-1:0]           lane_idx;
   logic                    last_lane;
   logic                    accept;
   logic [7:0]              cw;
   logic [3:0]              syn;
   logic [3:0]              nib;
   logic                    lane_corr;
   logic                    lane_derr;
   logic [DATA_WIDTH/2-1:0] data_q;
   logic [N-1:0]            corr_q;
   logic [N-1:0]            err_q;

   assign accept    = bus.in_valid && (state == IDLE);
   assign last_lane = (lane_idx == LW'(N - 1));

   always_comb begin
      cw = '0;
      for (int i = 0; i < N; i++) begin
         if (lane_idx == LW'(i)) begin
            cw = lane_buf[8*i +: 8];
         end
      end
   end

   // Only flips landing on c[7:4] change the nibble; check-bit hits just raise the flag.
   always_comb begin
      syn[3]    = ^cw;
      syn[2]    = cw[7] ^ cw[6] ^ cw[5] ^ cw[2];
      syn[1]    = cw[7] ^ cw[6] ^ cw[4] ^ cw[1];
      syn[0]    = cw[7] ^ cw[5] ^ cw[4] ^ cw[0];
      nib       = cw[7:4];
      lane_corr = 1'b0;
      lane_derr = 1'b0;
      if (syn[3]) begin
         lane_corr = 1'b1;
         case (syn[2:0])
            3'd7:    nib[3] = ~cw[7];
            3'd6:    nib[2] = ~cw[6];
            3'd5:    nib[1] = ~cw[5];
            3'd3:    nib[0] = ~cw[4];
            default: nib    = cw[7:4];
         endcase
      end else if (syn[2:0] != 3'd0) begin
         lane_derr = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = DECODE;
         DECODE:  if (last_lane) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
   end

   // Results are written in place lane by lane and then simply held until the next accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_buf <= '0;
         lane_idx <= '0;
         data_q   <= '0;
         corr_q   <= '0;
         err_q    <= '0;
      end else if (accept) begin
         lane_buf <= bus.in_data;
         lane_idx <= '0;
         corr_q   <= '0;
         err_q    <= '0;
      end else if (state == DECODE) begin
         for (int i = 0; i < N; i++) begin
            if (lane_idx == LW'(i)) begin
               data_q[4*i +: 4] <= nib;
               corr_q[i]        <= lane_corr;
               err_q[i]         <= lane_derr;
            end
         end
         lane_idx <= lane_idx + 1'b1;
      end
   end

   assign bus.out_data = data_q;
   assign bus.out_corr = corr_q;
   assign bus.out_err  = err_q;

`ifdef ECC_DEC_STATS_EN
   logic [15:0] corr_q16;
   logic [15:0] derr_q16;

   // Saturating counters; a clear takes priority over a same-cycle increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         corr_q16 <= '0;
         derr_q16 <= '0;
      end else if (cnt_clr) begin
         corr_q16 <= '0;
         derr_q16 <= '0;
      end else if (state == DECODE) begin
         if (lane_corr && (corr_q16 != 16'hFFFF)) begin
            corr_q16 <= corr_q16 + 16'd1;
         end
         if (lane_derr && (derr_q16 != 16'hFFFF)) begin
            derr_q16 <= derr_q16 + 16'd1;
         end
      end
   end

   assign corr_cnt = corr_q16;
   assign derr_cnt = derr_q16;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign corr_cnt       = 16'd0;
   assign derr_cnt       = 16'd0;
`endif
endmodule

// File: tb/tb_ecc_dec_ctrl.sv
// Directed self-checking bench for ecc_dec_ctrl at DATA_WIDTH=32; expected values
// are hand-computed codewords. Counter expectations follow ECC_DEC_STATS_EN.
module tb_ecc_dec_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cnt_clr = 1'b0;
   logic [15:0] corr_cnt;
   logic [15:0] derr_cnt;
   int          tests_run = 0;
   int          tests_failed = 0;

`ifdef ECC_DEC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   ecc_dec_ctrl_if #(.DATA_WIDTH(32)) bus();

   ecc_dec_ctrl #(.DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .cnt_clr  (cnt_clr),
      .corr_cnt (corr_cnt),
      .derr_cnt (derr_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] word, output int lat);
      @(negedge clk);
      checkOutput("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = word;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Sends one word, checks the result, optionally stalls the consumer, then completes the handshake.
   task automatic runWord(input logic [31:0] word, input logic [15:0] exp_data,
                          input logic [3:0] exp_corr, input logic [3:0] exp_err, input int hold);
      int lat;
      bus.out_ready = (hold == 0);
      applyStimulus(word, lat);
      checkOutput("valid_latency", 32'(lat), 32'd4);
      checkOutput("out_data", 32'(bus.out_data), 32'(exp_data));
      checkOutput("out_corr", 32'(bus.out_corr), 32'(exp_corr));
      checkOutput("out_err", 32'(bus.out_err), 32'(exp_err));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         bus.in_valid = k[0];
         bus.in_data  = 32'h1234_5678 ^ 32'(k);
         @(posedge clk);
         #1;
         checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
         checkOutput("stall_out_data", 32'(bus.out_data), 32'(exp_data));
         checkOutput("stall_flags", 32'({bus.out_corr, bus.out_err}), 32'({exp_corr, exp_err}));
      end
      if (hold > 0) begin
         @(negedge clk);
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("idle_out_data_held", 32'(bus.out_data), 32'(exp_data));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
      checkOutput("rst_flags", 32'({bus.out_corr, bus.out_err}), 32'd0);
      checkOutput("rst_counters", {corr_cnt, derr_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      runWord(32'hFFFF_FFFF, 16'hFFFF, 4'b0000, 4'b0000, 0);
      checkOutput("clean_corr_cnt", 32'(corr_cnt), 32'd0);
      runWord(32'hFFFF_FFEF, 16'hFFFF, 4'b0001, 4'b0000, 0);
      runWord(32'hFFF7_FFFF, 16'hFFFF, 4'b0100, 4'b0000, 0);
      runWord(32'hFCFF_FFFF, 16'hFFFF, 4'b0000, 4'b1000, 0);
      checkOutput("corr_cnt_after3", 32'(corr_cnt), STATS ? 32'd2 : 32'd0);
      checkOutput("derr_cnt_after3", 32'(derr_cnt), STATS ? 32'd1 : 32'd0);

      @(negedge clk);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      checkOutput("cnt_clr_both", {corr_cnt, derr_cnt}, 32'd0);

      // Lanes AA/55/36/C9 are clean codewords for nibbles A/5/3/C.
      runWord(32'hC9A6_152A, 16'hCA5A, 4'b0011, 4'b0100, 0);
      checkOutput("corr_cnt_mixed", 32'(corr_cnt), STATS ? 32'd2 : 32'd0);
      checkOutput("derr_cnt_mixed", 32'(derr_cnt), STATS ? 32'd1 : 32'd0);
      runWord(32'hC936_55AA, 16'hC35A, 4'b0000, 4'b0000, 10);

      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hFFFF_FFEF;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("midrst_out_data", 32'(bus.out_data), 32'd0);
      checkOutput("midrst_flags", 32'({bus.out_corr, bus.out_err}), 32'd0);
      checkOutput("midrst_counters", {corr_cnt, derr_cnt}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      runWord(32'h0000_0000, 16'h0000, 4'b0000, 4'b0000, 0);
      checkOutput("post_rst_counters", {corr_cnt, derr_cnt}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
